// File: rtl/math_pkg.sv
// Shared definitions for the Newton-Raphson square-root engine.
// Holds the controller state encoding, the counter-width helper used for
// both the iteration counter and the divider step counter, and the fallback
// seed shift applied when the initial-value generator returns zero.
package math_pkg;

  // Controller states (legacy-compatible plain constants).
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCheck   = 3'd1;
  localparam logic [2:0] StSeed    = 3'd2;
  localparam logic [2:0] StWaitLow = 3'd3;
  localparam logic [2:0] StDiv     = 3'd4;
  localparam logic [2:0] StUpdate  = 3'd5;
  localparam logic [2:0] StDone    = 3'd6;

  // Bits needed to count from 0 up to and including n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // A zero seed is replaced by 1 << seed_shift(width), an upper bound on sqrt(x).
  function automatic int unsigned seed_shift(input int unsigned width);
    return (width + 1) / 2;
  endfunction

endpackage

// File: rtl/sqrt_newton_ctrl_div.sv
// Sequential restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (aborts any division)
//   start     - begin a = q*b + r; ignored while a division is in progress
//   a, b      - dividend and divisor, sampled on the start cycle
//   q         - quotient, valid while done=1 and held afterwards
//   done      - one-cycle pulse, Width cycles after start was accepted
// b == 0 yields q = all ones.
module sqrt_div_seq
  import math_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] q,
  output logic             done
);

  localparam int unsigned CntW = cnt_width(Width);

  logic [Width-1:0] rem_q, rem_d, quo_q, quo_d, b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy, load, ge;
  logic [Width-1:0] rem_cur, quo_cur, b_cur;
  logic [Width:0]   trial;

  assign busy = (cnt_q != '0);
  assign load = start && !busy;

  // The first quotient bit is produced on the accepting edge itself, so the
  // whole division spans exactly Width edges and done lands in the Width-th cycle.
  always_comb begin
    rem_cur = load ? '0 : rem_q;
    quo_cur = load ? a  : quo_q;
    b_cur   = load ? b  : b_q;
    trial   = {rem_cur, quo_cur[Width-1]};
    ge      = (trial >= {1'b0, b_cur});
    rem_d   = rem_q;
    quo_d   = quo_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load || busy) begin
      rem_d  = ge ? Width'(trial - {1'b0, b_cur}) : Width'(trial);
      quo_d  = {quo_cur[Width-2:0], ge};
      b_d    = b_cur;
      cnt_d  = load ? CntW'(Width - 1) : cnt_q - CntW'(1);
      done_d = load ? (Width == 1) : (cnt_q == CntW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q    = quo_q;
  assign done = done_q;

endmodule

// File: rtl/sqrt_newton_ctrl.sv
// Newton-Raphson integer square root: y = floor(sqrt(x)).
// Requests a seed from the initial-value generator, then iterates
// y' = (y + x/y) >> 1 until the sequence stops decreasing.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   req / fin          - upstream 4-phase handshake; x latched on acceptance
//   x                  - radicand
//   y, err             - result and iteration-bound flag, valid while fin=1
//   init_req/init_fin  - downstream 4-phase seed handshake
//   init_x             - latched radicand presented to the generator
//   init_y             - seed, captured on the first cycle init_fin=1
module sqrt_newton_ctrl
  import math_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter int unsigned MaxIter = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [Width-1:0] x,
  output logic             fin,
  output logic [Width-1:0] y,
  output logic             err,
  output logic             init_req,
  input  logic             init_fin,
  output logic [Width-1:0] init_x,
  input  logic [Width-1:0] init_y
);

  localparam int unsigned IterW     = cnt_width(MaxIter);
  localparam int unsigned SeedShift = seed_shift(Width);

  logic [2:0]       state_q, state_d;
  logic [Width-1:0] xr_q, xr_d, yc_q, yc_d, y_q, y_d;
  logic             err_q, err_d;
  logic [IterW-1:0] iter_q, iter_d;

  logic             div_start, div_done;
  logic [Width-1:0] div_q;
  logic [Width:0]   sum;
  logic [Width-1:0] yn, seed_raw, seed;

  always_comb begin
    seed_raw = (init_y == '0) ? (Width'(1) << SeedShift) : init_y;
    seed     = (seed_raw > xr_q) ? xr_q : seed_raw;
    // Extra bit keeps yc + q from overflowing.
    sum      = {1'b0, yc_q} + {1'b0, div_q};
    yn       = Width'(sum >> 1);
  end

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yc_d    = yc_q;
    y_d     = y_q;
    err_d   = err_q;
    iter_d  = iter_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          xr_d    = x;
          state_d = StCheck;
        end
      end
      StCheck: begin
        iter_d = '0;
        if (xr_q == '0) begin
          y_d     = '0;
          state_d = StDone;
        end else if (xr_q < Width'(4)) begin
          y_d     = Width'(1);
          state_d = StDone;
        end else begin
          state_d = StSeed;
        end
      end
      StSeed: begin
        if (init_fin) begin
          yc_d    = seed;
          state_d = StWaitLow;
        end
      end
      StWaitLow: begin
        if (!init_fin) state_d = StDiv;
      end
      StDiv: begin
        if (div_done) state_d = StUpdate;
      end
      StUpdate: begin
        iter_d = iter_q + IterW'(1);
        // The first step is always taken so a low seed gets pulled above sqrt(x).
        if ((iter_q != '0) && (yn >= yc_q)) begin
          y_d     = yc_q;
          state_d = StDone;
        end else if (iter_d == IterW'(MaxIter)) begin
          y_d     = yn;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          yc_d    = yn;
          state_d = StDiv;
        end
      end
      StDone: begin
        if (!req) begin
          y_d     = '0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Launch the divider on the edge that enters DIV, with the divisor DIV will use.
  assign div_start = (state_d == StDiv) && (state_q != StDiv);

  sqrt_div_seq #(
    .Width (Width)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .a     (xr_q),
    .b     (yc_d),
    .q     (div_q),
    .done  (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      xr_q    <= '0;
      yc_q    <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yc_q    <= yc_d;
      y_q     <= y_d;
      err_q   <= err_d;
      iter_q  <= iter_d;
    end
  end

  assign fin      = (state_q == StDone);
  assign y        = y_q;
  assign err      = err_q;
  assign init_req = (state_q == StSeed);
  assign init_x   = xr_q;

endmodule
